// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit that owns the HI and LO
// architectural registers. Multiplies finish after MUL_LAT edges. Divides
// use a restoring algorithm on operand magnitudes, one quotient bit per
// edge, followed by a single sign-fixup cycle. HI/LO change only when an
// operation completes or on MTHI/MTLO, so intermediate values never reach
// the write-back mux.
module muldiv_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_LAT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        cancel,
    output logic [31:0] regHi,
    output logic [31:0] regLo,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    // a_q holds the multiplicand, or the dividend magnitude that shifts
    // left and fills with quotient bits during a divide.
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic        mul_signed_q, mul_signed_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;

    logic        accept;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] mul_a64;
    logic [63:0] mul_b64;
    logic [63:0] product;
    logic [32:0] rem_shift;
    logic        rem_ge;

    assign regHi = hi_q;
    assign regLo = lo_q;
    assign busy  = (state_q != IDLE);

    // Sign-extended 64-bit multiply; the low 64 bits are the exact product
    // for both signed and unsigned operands.
    always_comb begin
        mul_a64 = {{32{mul_signed_q & a_q[31]}}, a_q};
        mul_b64 = {{32{mul_signed_q & b_q[31]}}, b_q};
        product = mul_a64 * mul_b64;
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits.
    always_comb begin
        rem_shift = {rem_q, a_q[31]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
    end

    // Next-state, counter and HI/LO update logic; cancel overrides all.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        mul_signed_d = mul_signed_q;
        quot_neg_d   = quot_neg_q;
        rem_neg_d    = rem_neg_q;
        div_zero_d   = div_zero_q;
        neg_a        = 1'b0;
        neg_b        = 1'b0;
        accept       = start && !cancel && (state_q == IDLE)
                       && (op != 3'b000) && (op != 3'b111);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MTHI: hi_d = opA;
                        OP_MTLO: lo_d = opA;
                        OP_MULT, OP_MULTU: begin
                            a_d          = opA;
                            b_d          = opB;
                            mul_signed_d = (op == OP_MULT);
                            cnt_d        = 8'd0;
                            state_d      = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            neg_a      = (op == OP_DIV) && opA[31];
                            neg_b      = (op == OP_DIV) && opB[31];
                            a_d        = neg_a ? -opA : opA;
                            b_d        = neg_b ? -opB : opB;
                            rem_d      = 32'd0;
                            quot_neg_d = neg_a ^ neg_b;
                            rem_neg_d  = neg_a;
                            div_zero_d = (opB == 32'd0);
                            cnt_d      = 8'd0;
                            state_d    = DIV;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == 8'(MUL_LAT - 1)) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DIV: begin
                rem_d = rem_ge ? 32'(rem_shift - {1'b0, b_q}) : rem_shift[31:0];
                a_d   = {a_q[30:0], rem_ge};
                if (cnt_q == 8'(DIV_CYCLES - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIX: begin
                // A zero divisor always reports an all-ones quotient, whatever
                // the dividend sign; the remainder already equals opA.
                lo_d    = div_zero_q ? 32'hFFFF_FFFF : (quot_neg_q ? -a_q : a_q);
                hi_d    = rem_neg_q ? -rem_q : rem_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rem_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            quot_neg_q   <= 1'b0;
            rem_neg_q    <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            mul_signed_q <= mul_signed_d;
            quot_neg_q   <= quot_neg_d;
            rem_neg_q    <= rem_neg_d;
            div_zero_q   <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed test of muldiv_unit with hand-computed results.
module tb_muldiv_unit;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic        cancel = 1'b0;
    logic [31:0] regHi;
    logic [31:0] regLo;
    logic        busy;

    int total_checks = 0;
    int passed_checks = 0;
    int cycles;

    muldiv_unit #(.DIV_CYCLES(32), .MUL_LAT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .cancel (cancel),
        .regHi  (regHi),
        .regLo  (regLo),
        .busy   (busy)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Issue one operation, scramble the operands after acceptance, and count
    // edges until busy drops (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        tick();
        start = 1'b0;
        op    = OP_NOP;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'h1357_9BDF;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Directed step sequence.
    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_hi", regHi, 32'h0);
        check("reset_lo", regLo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, cycles);
        check("mult_latency", cycles, 32'd4);
        check("mult_hi", regHi, 32'hFFFF_FFFF);
        check("mult_lo", regLo, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, cycles);
        check("multu_latency", cycles, 32'd4);
        check("multu_hi", regHi, 32'h0000_0001);
        check("multu_lo", regLo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, cycles);
        check("div_latency", cycles, 32'd33);
        check("div_neg_lo", regLo, 32'hFFFF_FFFD);
        check("div_neg_hi", regHi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7, cycles);
        check("divu_latency", cycles, 32'd33);
        check("divu_lo", regLo, 32'd14);
        check("divu_hi", regHi, 32'd2);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
        check("div_ovf_lo", regLo, 32'h8000_0000);
        check("div_ovf_hi", regHi, 32'h0);

        run_op(OP_DIV, 32'd5, 32'd0, cycles);
        check("div0_latency", cycles, 32'd33);
        check("div0_lo", regLo, 32'hFFFF_FFFF);
        check("div0_hi", regHi, 32'd5);

        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, cycles);
        check("div0_neg_lo", regLo, 32'hFFFF_FFFF);
        check("div0_neg_hi", regHi, 32'hFFFF_FFFB);

        // MTHI: immediate write, never busy.
        start = 1'b1; op = OP_MTHI; opA = 32'h1234;
        tick();
        start = 1'b0; op = OP_NOP;
        check("mthi_hi", regHi, 32'h1234);
        check("mthi_lo_kept", regLo, 32'hFFFF_FFFF);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // Cancel a divide ten edges in; HI/LO keep their prior values.
        start = 1'b1; op = OP_DIV; opA = 32'd100; opB = 32'd7;
        tick();
        start = 1'b0; op = OP_NOP;
        check("cancel_busy_before", {31'd0, busy}, 32'd1);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", regHi, 32'h1234);
        check("cancel_lo", regLo, 32'hFFFF_FFFF);
        repeat (30) tick();
        check("cancel_hi_later", regHi, 32'h1234);
        check("cancel_lo_later", regLo, 32'hFFFF_FFFF);

        // MTLO issued while a divide is busy is ignored.
        start = 1'b1; op = OP_DIVU; opA = 32'd100; opB = 32'd7;
        tick();
        op = OP_MTLO; opA = 32'hAAAA;
        tick();
        start = 1'b0; op = OP_NOP;
        check("ignored_lo", regLo, 32'hFFFF_FFFF);
        check("ignored_busy", {31'd0, busy}, 32'd1);
        cycles = 1;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
        check("ignored_latency", cycles, 32'd33);
        check("ignored_final_lo", regLo, 32'd14);
        check("ignored_final_hi", regHi, 32'd2);

        // start with cancel in the same cycle is never accepted.
        start = 1'b1; cancel = 1'b1; op = OP_MTHI; opA = 32'h5555;
        tick();
        check("start_cancel_mthi", regHi, 32'd2);
        op = OP_MULT; opA = 32'd3; opB = 32'd3;
        tick();
        start = 1'b0; cancel = 1'b0; op = OP_NOP;
        check("start_cancel_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check("start_cancel_lo", regLo, 32'd14);

        // Reset in the middle of a multiply.
        start = 1'b1; op = OP_MULTU; opA = 32'd6; opB = 32'd7;
        tick();
        start = 1'b0; op = OP_NOP;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", regHi, 32'h0);
        check("midrst_lo", regLo, 32'h0);
        repeat (5) tick();
        check("midrst_lo_later", regLo, 32'h0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit owning the HI and LO architectural registers. It sits in the EX stage beside the ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations. Its registered `regHi`/`regLo` outputs feed the MEM stage's write-back mux for MFHI/MFLO. The `busy` output drives pipeline stall control.

## Interface
- `DIV_CYCLES`, default 32: restoring-division iteration count; must equal the operand width.
- `MUL_LAT`, default 4: edges from an accepted multiply to the HI/LO update; minimum 1.

- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: issue strobe; sampled on posedge.
- `op`, input, 3: operation code.
  - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 000 and 111 are no-ops.
- `opA`, input, 32: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `opB`, input, 32: rt operand (multiplier or divisor).
- `cancel`, input, 1: abort the in-flight operation (exception flush).
- `regHi`, output, 32: HI register.
- `regLo`, output, 32: LO register.
- `busy`, output, 1: an operation is in flight; registered.

## Operation
- States:
  - IDLE: no operation in flight.
  - MUL: counter runs to `MUL_LAT`.
  - DIV: counter runs to `DIV_CYCLES`.
  - FIX: one cycle of sign correction and write.
- An operation is accepted when `start=1`, `busy=0`, `cancel=0` and `op` is not a no-op.
- `start` while `busy=1` is ignored. Pipeline control must stall instead; the bench checks that it is ignored.
- MTHI/MTLO:
  - HI (or LO) is loaded with `opA` at the accepting edge.
  - Stays in IDLE; `busy` stays 0.
- MULT/MULTU:
  - Full 64-bit product, signed or unsigned.
  - {HI,LO} is loaded at the edge ending the MUL state; then return to IDLE.
  - Operands are latched at acceptance, so `opA`/`opB` may change afterwards.
- DIV/DIVU, restoring algorithm on magnitudes:
  - Latch |opA| and |opB| (signed) or the raw values (unsigned), plus the two sign flags.
  - One quotient bit per edge in DIV.
  - FIX: negate the quotient if the operand signs differ. The remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Division by zero: no trap. Result is LO=0xFFFFFFFF, HI=opA, for both DIV and DIVU, with the normal latency.
- Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `cancel` has priority over everything:
  - In-flight work is discarded and HI/LO keep their pre-operation values.
  - The state goes to IDLE and `busy=0` after the edge.
  - A `start` in the same cycle is not accepted.
- HI/LO are written only at operation completion or by MTHI/MTLO. Intermediate values never appear on `regHi`/`regLo`.

## Timing
- Reset, at the first posedge with `rst=1`: `regHi`=0, `regLo`=0, `busy`=0, state IDLE, counters 0. `rst` overrides `start` and `cancel`.
- Call the accepting edge E0.
- MTHI/MTLO: the new value is visible on `regHi`/`regLo` right after E0.
- Multiply:
  - `busy`=1 after E0.
  - HI/LO are updated and `busy`=0 after E(`MUL_LAT`); default E4.
- Divide:
  - `busy`=1 after E0.
  - Iterations run on edges E1..E32.
  - The FIX write happens at E33; HI/LO are valid and `busy`=0 after E33.
- Back-to-back issue: a new `start` is accepted in the first cycle in which `busy`=0.
- Reset mid-operation: the operation is abandoned and all outputs return to reset values.

## Test plan
- Reset, then MULT with opA=0xFFFFFFFF, opB=2 -> `busy` high for 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> `busy` high for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234 -> HI=0x1234 next cycle with no `busy`. Then start DIV 100 / 7 and assert `cancel` 10 cycles in -> `busy`=0 next cycle, HI=0x1234 and LO unchanged.
- During a DIV, assert `start` with MTLO 0xAAAA -> ignored; LO equals the quotient at the end.
- `start` and `cancel` in the same cycle -> no operation accepted.
